lives_hud: RTL and testbench
============================

Name: lives_hud

Overview:
- Parametrised lives indicator for the VGA HUD. Draws up to MAX_LIVES icons in one tile row.
- Animates life changes: a lost icon blinks and then disappears; a gained icon appears and blinks.
- Sits beside the maze/sprite renderers. lives_dr and lives_RGB feed the priority mux. offset_x/offset_y feed bitmap lookup.

Parameters:
- MAX_LIVES, 5: maximum icons drawn; lives input saturates here.
- TILE_SIZE, 16: tile edge in pixels; must be a power of two.
- START_X, 1: tile column of icon 0.
- ROW_Y, 30: tile row of the icon strip.
- BLINK_FRAMES, 48: frames an animation lasts.
- BLINK_PERIOD, 8: frames per visible/invisible half-phase.
- ICON_RGB, 8'hFC: icon colour (yellow).
- TRNS_RGB, 8'hFF: transparent code.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- lives  in  3  game lives count; values above MAX_LIVES are treated as MAX_LIVES
- startOfFrame  in  1  one-cycle pulse per frame
- pixel_x  in  11  current pixel column
- pixel_y  in  11  current pixel row
- lives_dr  out  1  draw request; high iff lives_RGB != TRNS_RGB
- lives_RGB  out  8  pixel colour
- offset_x  out  11  pixel_x mod TILE_SIZE, registered
- offset_y  out  11  pixel_y mod TILE_SIZE, registered
- anim_busy  out  1  high while state is LOSE or GAIN

Behaviour:
- Reset (async, resetN low):
  - lives_RGB=TRNS_RGB, lives_dr=0, offsets=0, anim_busy=0.
  - shown=0, frame_cnt=0, state=INIT.
- Pixel path: 1-cycle latency. lives_RGB, lives_dr and offsets are all registered from the same pixel_x/pixel_y sample, so they stay aligned.
  - tile_x = pixel_x / TILE_SIZE; tile_y = pixel_y / TILE_SIZE.
  - k = tile_x - START_X, computed signed/wide so that tile_x < START_X never matches.
  - Draw ICON_RGB iff tile_y==ROW_Y, 0<=k<shown, and (k!=blink_idx or blink_on). Otherwise draw TRNS_RGB.
- Control updates only on a cycle where startOfFrame=1. lives is sampled then (lives_sat = min(lives, MAX_LIVES)); mid-frame lives changes are ignored.
- blink_on = ((frame_cnt / BLINK_PERIOD) is even) ? 0 : 1, i.e. the icon is hidden during the first half-phase.
- States:
  - INIT: shown<=lives_sat, no animation, go to IDLE.
  - IDLE: if lives_sat<shown: blink_idx<=shown-1, frame_cnt<=0, go to LOSE. Else if lives_sat>shown: shown<=shown+1, blink_idx<=shown (old value), frame_cnt<=0, go to GAIN. Else stay in IDLE.
  - LOSE: frame_cnt++. When frame_cnt==BLINK_FRAMES-1: shown<=shown-1, go to IDLE.
  - GAIN: frame_cnt++. When frame_cnt==BLINK_FRAMES-1: go to IDLE.
- Multi-step changes animate one icon at a time. Each step starts on the frame after IDLE is re-entered. Example: 3→1 is two LOSE sequences.
- A lives change during LOSE or GAIN does not abort the animation. It is re-evaluated in IDLE afterwards.
- blink_idx is meaningful only in LOSE/GAIN. In IDLE every k<shown is drawn solid.
- Widths:
  - frame_cnt width is clog2(BLINK_FRAMES)+1.
  - shown width is 3 bits; shown never exceeds MAX_LIVES and never underflows below 0.
- Reset mid-animation: the animation is abandoned. The next startOfFrame reloads shown directly via INIT.
- lives=0 with shown=0: nothing is drawn; anim_busy=0.

Optional Feature:
- LIVES_HUD_ROUND_ICON_EN defined: an icon pixel is drawn only if (2*offset_x-TILE_SIZE+1)^2 + (2*offset_y-TILE_SIZE+1)^2 <= TILE_SIZE^2, giving a disc. This is computed from the current pixel so it stays in the same 1-cycle pipeline.
- Undefined: the full TILE_SIZE square is drawn.
- Control behaviour is identical in both cases.

Test Plan:
- Reset, lives=3, one startOfFrame → shown=3. Pixel (16,480) → ICON_RGB and dr=1 one cycle later. (64,480) and (0,480) → TRNS_RGB. anim_busy stays 0.
- shown=3, lives→2 at a frame start → anim_busy=1. Icon 2 (pixel 48,480) hidden for frames 0-7 and shown for frames 8-15. After 48 frames, (48,480) is TRNS and anim_busy=0.
- shown=1, lives=3 → GAIN: shown=2 immediately with icon 1 blinking. After 48 frames a second GAIN starts. Final shown=3 after 96 frames plus 2 IDLE frames.
- lives=7 with MAX_LIVES=5 → 5 icons drawn. Pixel (96,480) is TRNS.
- resetN pulsed during LOSE (frame_cnt=20) → all outputs go to reset values at once. Next startOfFrame loads shown=lives with no blink.
- With LIVES_HUD_ROUND_ICON_EN: icon tile corner (16,480) → TRNS; centre (24,488) → ICON_RGB.

Source files
------------

// File: rtl/lives_hud.sv
// lives_hud: VGA HUD lives indicator.
// Draws up to MAX_LIVES icons in one tile row and animates life changes.
// A lost icon blinks and then disappears. A gained icon appears and blinks.
// Multi-step changes are animated one icon at a time.
// Optional build macro: LIVES_HUD_ROUND_ICON_EN draws each icon as a disc
// inscribed in its tile. Without it, the full tile square is drawn.
// Pixel path latency is one clock. Control state advances only on startOfFrame.

module lives_hud #(
  parameter int unsigned MAX_LIVES    = 5,
  parameter int unsigned TILE_SIZE    = 16,
  parameter int unsigned START_X      = 1,
  parameter int unsigned ROW_Y        = 30,
  parameter int unsigned BLINK_FRAMES = 48,
  parameter int unsigned BLINK_PERIOD = 8,
  parameter logic [7:0]  ICON_RGB     = 8'hFC,
  parameter logic [7:0]  TRNS_RGB     = 8'hFF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [2:0]  lives,
  input  logic        startOfFrame,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic        lives_dr,
  output logic [7:0]  lives_RGB,
  output logic [10:0] offset_x,
  output logic [10:0] offset_y,
  output logic        anim_busy
);

  localparam int unsigned     TILE_SHIFT  = $clog2(TILE_SIZE);
  localparam int unsigned     FC_W        = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FC_W-1:0] FC_LAST     = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0] FC_PERIOD   = FC_W'(BLINK_PERIOD);
  localparam logic [2:0]      MAX_LIVES_3 = 3'(MAX_LIVES);
  localparam logic [10:0]     TILE_MASK   = 11'(TILE_SIZE - 1);
  localparam logic [10:0]     ROW_Y_11    = 11'(ROW_Y);
  localparam logic [11:0]     START_X_12  = 12'(START_X);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOSE = 2'd2,
    ST_GAIN = 2'd3
  } state_t;

  // Control registers
  state_t          state_q;
  logic [2:0]      shown_q;
  logic [2:0]      blink_idx_q;
  logic [FC_W-1:0] frame_cnt_q;
  logic            anim_busy_q;

  // Pixel pipeline registers and their next values
  logic [7:0]  rgb_q,  rgb_d;
  logic        dr_q,   dr_d;
  logic [10:0] offx_q, offx_d;
  logic [10:0] offy_q, offy_d;

  // Combinational helpers
  logic [2:0]        lives_sat;
  logic [10:0]       tile_x;
  logic [10:0]       tile_y;
  logic signed [11:0] k;
  logic              in_strip;
  logic              k_valid;
  logic [FC_W-1:0]   phase;
  logic              blink_on;
  logic              animating;
  logic              hide_icon;
  logic              in_shape;
  logic              icon_px;

`ifdef LIVES_HUD_ROUND_ICON_EN
  logic signed [12:0] disc_dx;
  logic signed [12:0] disc_dy;
  logic signed [25:0] disc_dx2;
  logic signed [25:0] disc_dy2;
  logic [26:0]        disc_dist;
`endif

  // Clamp the incoming lives count to the number of icon slots
  always_comb begin
    lives_sat = lives;
    if (lives > MAX_LIVES_3) begin
      lives_sat = MAX_LIVES_3;
    end else begin
      lives_sat = lives;
    end
  end

  // Lives state machine: one icon step per animation, advanced once per frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_INIT;
      shown_q     <= 3'd0;
      blink_idx_q <= 3'd0;
      frame_cnt_q <= '0;
      anim_busy_q <= 1'b0;
    end else if (startOfFrame) begin
      case (state_q)
        ST_INIT: begin
          // After reset the icon count is loaded without any animation
          shown_q     <= lives_sat;
          frame_cnt_q <= '0;
          anim_busy_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (lives_sat < shown_q) begin
            blink_idx_q <= shown_q - 3'd1;
            frame_cnt_q <= '0;
            anim_busy_q <= 1'b1;
            state_q     <= ST_LOSE;
          end else if (lives_sat > shown_q) begin
            // The new icon becomes visible immediately and blinks in place
            shown_q     <= shown_q + 3'd1;
            blink_idx_q <= shown_q;
            frame_cnt_q <= '0;
            anim_busy_q <= 1'b1;
            state_q     <= ST_GAIN;
          end else begin
            anim_busy_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_LOSE: begin
          if (frame_cnt_q == FC_LAST) begin
            // Icon disappears only once its blink sequence is complete
            if (shown_q != 3'd0) begin
              shown_q <= shown_q - 3'd1;
            end else begin
              shown_q <= 3'd0;
            end
            frame_cnt_q <= '0;
            anim_busy_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            frame_cnt_q <= frame_cnt_q + FC_W'(1);
            anim_busy_q <= 1'b1;
            state_q     <= ST_LOSE;
          end
        end
        ST_GAIN: begin
          if (frame_cnt_q == FC_LAST) begin
            frame_cnt_q <= '0;
            anim_busy_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            frame_cnt_q <= frame_cnt_q + FC_W'(1);
            anim_busy_q <= 1'b1;
            state_q     <= ST_GAIN;
          end
        end
        default: begin
          frame_cnt_q <= '0;
          anim_busy_q <= 1'b0;
          state_q     <= ST_INIT;
        end
      endcase
    end
  end

  // Tile coordinates and icon slot index of the current pixel
  always_comb begin
    tile_x   = pixel_x >> TILE_SHIFT;
    tile_y   = pixel_y >> TILE_SHIFT;
    // Widened and signed so columns left of START_X give a negative slot
    k        = $signed({1'b0, tile_x}) - $signed(START_X_12);
    in_strip = (tile_y == ROW_Y_11);
    k_valid  = (!k[11]) && (k[10:0] < {8'd0, shown_q});
  end

  // Blink phase: icon hidden during the first half-phase of each period
  always_comb begin
    phase     = frame_cnt_q / FC_PERIOD;
    blink_on  = phase[0];
    animating = (state_q == ST_LOSE) || (state_q == ST_GAIN);
    if (animating && (k[10:0] == {8'd0, blink_idx_q}) && !blink_on) begin
      hide_icon = 1'b1;
    end else begin
      hide_icon = 1'b0;
    end
  end

`ifdef LIVES_HUD_ROUND_ICON_EN
  // Disc mask: distance from the tile centre, doubled to stay integral
  always_comb begin
    disc_dx   = $signed({1'b0, offx_d, 1'b0}) - $signed(13'(TILE_SIZE)) + 13'sd1;
    disc_dy   = $signed({1'b0, offy_d, 1'b0}) - $signed(13'(TILE_SIZE)) + 13'sd1;
    disc_dx2  = disc_dx * disc_dx;
    disc_dy2  = disc_dy * disc_dy;
    disc_dist = {1'b0, disc_dx2} + {1'b0, disc_dy2};
    if (disc_dist <= 27'(TILE_SIZE * TILE_SIZE)) begin
      in_shape = 1'b1;
    end else begin
      in_shape = 1'b0;
    end
  end
`else
  // Square icons cover the whole tile
  always_comb begin
    in_shape = 1'b1;
  end
`endif

  // Next pixel colour, draw request and in-tile offsets
  always_comb begin
    offx_d  = pixel_x & TILE_MASK;
    offy_d  = pixel_y & TILE_MASK;
    icon_px = in_strip && k_valid && !hide_icon && in_shape;
    if (icon_px) begin
      rgb_d = ICON_RGB;
    end else begin
      rgb_d = TRNS_RGB;
    end
    dr_d = (rgb_d != TRNS_RGB);
  end

  // Pixel pipeline stage: all pixel outputs come from the same sample
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q  <= TRNS_RGB;
      dr_q   <= 1'b0;
      offx_q <= 11'd0;
      offy_q <= 11'd0;
    end else begin
      rgb_q  <= rgb_d;
      dr_q   <= dr_d;
      offx_q <= offx_d;
      offy_q <= offy_d;
    end
  end

  assign lives_RGB = rgb_q;
  assign lives_dr  = dr_q;
  assign offset_x  = offx_q;
  assign offset_y  = offy_q;
  assign anim_busy = anim_busy_q;

endmodule

// File: tb/tb_lives_hud.sv
// Testbench for lives_hud: directed scenarios plus randomized pixel/lives
// traffic checked against a frame-level behavioural model.
// Compile with +define+LIVES_HUD_ROUND_ICON_EN to exercise the disc icons.

module tb_lives_hud;

  localparam int MAXL   = 5;
  localparam int TILE   = 16;
  localparam int SX     = 1;
  localparam int ROWY   = 30;
  localparam int BFRM   = 48;
  localparam int BPER   = 8;
  localparam logic [7:0] ICON = 8'hFC;
  localparam logic [7:0] TRNS = 8'hFF;

  logic        clk;
  logic        resetN;
  logic [2:0]  lives;
  logic        startOfFrame;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        lives_dr;
  logic [7:0]  lives_RGB;
  logic [10:0] offset_x;
  logic [10:0] offset_y;
  logic        anim_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state (frame granularity)
  int m_shown;   // icons currently on screen
  bit m_init;    // first frame after reset still pending
  int m_anim;    // 0 none, -1 losing, +1 gaining
  int m_left;    // frames of the running animation still to show
  int m_idx;     // icon being animated

  logic [7:0]  exp_rgb;
  logic [10:0] exp_ox;
  logic [10:0] exp_oy;

  lives_hud dut (
    .clk          (clk),
    .resetN       (resetN),
    .lives        (lives),
    .startOfFrame (startOfFrame),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .lives_dr     (lives_dr),
    .lives_RGB    (lives_RGB),
    .offset_x     (offset_x),
    .offset_y     (offset_y),
    .anim_busy    (anim_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_shown = 0; m_init = 1'b1; m_anim = 0; m_left = 0; m_idx = 0;
  endfunction

  // One frame boundary, with the lives value seen at that boundary
  function automatic void model_frame(input int lv);
    int ls;
    ls = (lv > MAXL) ? MAXL : lv;
    if (m_init) begin
      m_shown = ls; m_init = 1'b0;
    end else if (m_anim != 0) begin
      if (m_left == 1) begin
        if (m_anim < 0) m_shown = m_shown - 1;
        m_anim = 0;
      end else begin
        m_left = m_left - 1;
      end
    end else if (ls < m_shown) begin
      m_anim = -1; m_idx = m_shown - 1; m_left = BFRM;
    end else if (ls > m_shown) begin
      m_anim = 1; m_idx = m_shown; m_shown = m_shown + 1; m_left = BFRM;
    end
  endfunction

  function automatic logic [7:0] model_rgb(input int px, input int py);
    int tx, ty, k, age, dx, dy;
    bit on;
    tx = px / TILE; ty = py / TILE; k = tx - SX;
    on = (ty == ROWY) && (k >= 0) && (k < m_shown);
    age = BFRM - m_left;
    if (on && (m_anim != 0) && (k == m_idx) && (((age / BPER) % 2) == 0)) on = 1'b0;
    dx = 2 * (px % TILE) - TILE + 1;
    dy = 2 * (py % TILE) - TILE + 1;
`ifdef LIVES_HUD_ROUND_ICON_EN
    if (dx * dx + dy * dy > TILE * TILE) on = 1'b0;
`endif
    return on ? ICON : TRNS;
  endfunction

  // Drive one pixel (called at a falling edge); returns at the next falling edge
  task automatic step(input int px, input int py, input bit sof);
    pixel_x = 11'(px); pixel_y = 11'(py); startOfFrame = sof;
    exp_rgb = model_rgb(px, py);
    exp_ox  = 11'(px % TILE);
    exp_oy  = 11'(py % TILE);
    @(posedge clk);
    if (sof) model_frame(int'(lives));
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; lives = 3'd0; startOfFrame = 1'b0;
    pixel_x = 11'd24; pixel_y = 11'd487;
    model_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL reset_rgb got %h exp %h", lives_RGB, TRNS); end
    tests_run++; if (lives_dr !== 1'b0) begin tests_failed++; $display("FAIL reset_dr got %b exp 0", lives_dr); end
    tests_run++; if (offset_x !== 11'd0) begin tests_failed++; $display("FAIL reset_offx got %0d exp 0", offset_x); end
    tests_run++; if (offset_y !== 11'd0) begin tests_failed++; $display("FAIL reset_offy got %0d exp 0", offset_y); end
    tests_run++; if (anim_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", anim_busy); end
    resetN = 1'b1;
  endtask

  task automatic test_basic();
    int bx[7] = '{16, 24, 64, 0, 40, 40, 37};
    int by[7] = '{480, 488, 480, 480, 479, 496, 485};
    lives = 3'd3;
    step(0, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(bx[i], by[i], 1'b0);
      tests_run++; if (lives_RGB !== exp_rgb) begin tests_failed++; $display("FAIL basic_rgb (%0d,%0d) got %h exp %h", bx[i], by[i], lives_RGB, exp_rgb); end
      tests_run++; if (lives_dr !== (exp_rgb != TRNS)) begin tests_failed++; $display("FAIL basic_dr (%0d,%0d) got %b", bx[i], by[i], lives_dr); end
      tests_run++; if (offset_x !== exp_ox || offset_y !== exp_oy) begin tests_failed++; $display("FAIL basic_off got %0d,%0d exp %0d,%0d", offset_x, offset_y, exp_ox, exp_oy); end
      tests_run++; if (anim_busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy got %b exp 0", anim_busy); end
    end
    step(56, 488, 1'b0);
    tests_run++; if (lives_RGB !== ICON) begin tests_failed++; $display("FAIL basic_icon2 got %h exp %h", lives_RGB, ICON); end
    step(72, 488, 1'b0);
    tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL basic_icon3 got %h exp %h", lives_RGB, TRNS); end
  endtask

  task automatic test_lose();
    lives = 3'd2;
    step(56, 488, 1'b1);
    tests_run++; if (anim_busy !== 1'b1) begin tests_failed++; $display("FAIL lose_busy_start got %b exp 1", anim_busy); end
    for (int f = 0; f < BFRM; f++) begin
      step(56, 488, 1'b0);
      tests_run++; if (lives_RGB !== exp_rgb) begin tests_failed++; $display("FAIL lose_blink frame %0d got %h exp %h", f, lives_RGB, exp_rgb); end
      if (f == 0 || f == 7) begin
        tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL lose_hidden frame %0d got %h exp %h", f, lives_RGB, TRNS); end
      end
      if (f == 8 || f == 15) begin
        tests_run++; if (lives_RGB !== ICON) begin tests_failed++; $display("FAIL lose_visible frame %0d got %h exp %h", f, lives_RGB, ICON); end
      end
      tests_run++; if (anim_busy !== 1'b1) begin tests_failed++; $display("FAIL lose_busy frame %0d got %b exp 1", f, anim_busy); end
      step(0, 0, 1'b1);
    end
    step(56, 488, 1'b0);
    tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL lose_gone got %h exp %h", lives_RGB, TRNS); end
    tests_run++; if (anim_busy !== 1'b0) begin tests_failed++; $display("FAIL lose_busy_end got %b exp 0", anim_busy); end
  endtask

  task automatic test_gain();
    lives = 3'd1;
    repeat (BFRM + 1) step(0, 0, 1'b1);
    lives = 3'd3;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 5; i++) begin
        step(24 + 16 * i, 480 + (f % 16), 1'b0);
        tests_run++; if (lives_RGB !== exp_rgb) begin tests_failed++; $display("FAIL gain_rgb frame %0d icon %0d got %h exp %h", f, i, lives_RGB, exp_rgb); end
      end
      tests_run++; if (anim_busy !== (m_anim != 0)) begin tests_failed++; $display("FAIL gain_busy frame %0d got %b exp %b", f, anim_busy, (m_anim != 0)); end
      step(0, 0, 1'b1);
    end
    step(56, 488, 1'b0);
    tests_run++; if (lives_RGB !== ICON) begin tests_failed++; $display("FAIL gain_final_icon2 got %h exp %h", lives_RGB, ICON); end
    step(72, 488, 1'b0);
    tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL gain_final_icon3 got %h exp %h", lives_RGB, TRNS); end
    tests_run++; if (anim_busy !== 1'b0) begin tests_failed++; $display("FAIL gain_final_busy got %b exp 0", anim_busy); end
  endtask

  task automatic test_saturate();
    lives = 3'd7;
    do_reset();
    step(0, 0, 1'b1);
    step(88, 488, 1'b0);
    tests_run++; if (lives_RGB !== ICON) begin tests_failed++; $display("FAIL sat_icon4 got %h exp %h", lives_RGB, ICON); end
    step(96, 480, 1'b0);
    tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL sat_icon5 got %h exp %h", lives_RGB, TRNS); end
    step(0, 0, 1'b1);
    step(88, 488, 1'b0);
    tests_run++; if (anim_busy !== 1'b0 || lives_RGB !== ICON) begin tests_failed++; $display("FAIL sat_stable busy %b rgb %h", anim_busy, lives_RGB); end
  endtask

  task automatic test_reset_mid();
    lives = 3'd3;
    do_reset();
    step(0, 0, 1'b1);
    lives = 3'd2;
    repeat (21) step(0, 0, 1'b1);
    step(24, 488, 1'b0);
    tests_run++; if (lives_RGB !== ICON || anim_busy !== 1'b1) begin tests_failed++; $display("FAIL rmid_before rgb %h busy %b", lives_RGB, anim_busy); end
    #2 resetN = 1'b0;
    #1;
    tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL rmid_rgb got %h exp %h", lives_RGB, TRNS); end
    tests_run++; if (lives_dr !== 1'b0) begin tests_failed++; $display("FAIL rmid_dr got %b exp 0", lives_dr); end
    tests_run++; if (offset_x !== 11'd0 || offset_y !== 11'd0) begin tests_failed++; $display("FAIL rmid_off got %0d,%0d exp 0,0", offset_x, offset_y); end
    tests_run++; if (anim_busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy got %b exp 0", anim_busy); end
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    lives = 3'd4;
    step(0, 0, 1'b1);
    for (int f = 0; f < 16; f++) begin
      step(72, 488, 1'b0);
      tests_run++; if (lives_RGB !== ICON) begin tests_failed++; $display("FAIL rmid_reload frame %0d got %h exp %h", f, lives_RGB, ICON); end
      tests_run++; if (anim_busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_nobusy frame %0d got %b exp 0", f, anim_busy); end
      step(0, 0, 1'b1);
    end
  endtask

  task automatic test_zero();
    lives = 3'd0;
    do_reset();
    step(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(16 * i + 8, 488, 1'b0);
      tests_run++; if (lives_RGB !== TRNS || anim_busy !== 1'b0) begin tests_failed++; $display("FAIL zero_slot %0d rgb %h busy %b", i, lives_RGB, anim_busy); end
    end
  endtask

  task automatic test_random();
    int px, py;
    bit sof;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 29) == 0) lives = 3'($urandom_range(0, 7));
      px  = $urandom_range(0, 119);
      py  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(470, 500);
      sof = ($urandom_range(0, 3) == 0);
      step(px, py, sof);
      tests_run++; if (lives_RGB !== exp_rgb) begin tests_failed++; $display("FAIL rand_rgb n=%0d (%0d,%0d) got %h exp %h", n, px, py, lives_RGB, exp_rgb); end
      tests_run++; if (lives_dr !== (exp_rgb != TRNS)) begin tests_failed++; $display("FAIL rand_dr n=%0d got %b", n, lives_dr); end
      tests_run++; if (offset_x !== exp_ox || offset_y !== exp_oy) begin tests_failed++; $display("FAIL rand_off n=%0d got %0d,%0d exp %0d,%0d", n, offset_x, offset_y, exp_ox, exp_oy); end
      tests_run++; if (anim_busy !== (m_anim != 0)) begin tests_failed++; $display("FAIL rand_busy n=%0d got %b exp %b", n, anim_busy, (m_anim != 0)); end
    end
  endtask

`ifdef LIVES_HUD_ROUND_ICON_EN
  task automatic test_round();
    lives = 3'd2;
    do_reset();
    step(0, 0, 1'b1);
    step(16, 480, 1'b0);
    tests_run++; if (lives_RGB !== TRNS) begin tests_failed++; $display("FAIL round_corner got %h exp %h", lives_RGB, TRNS); end
    step(24, 488, 1'b0);
    tests_run++; if (lives_RGB !== ICON) begin tests_failed++; $display("FAIL round_centre got %h exp %h", lives_RGB, ICON); end
    step(16, 488, 1'b0);
    tests_run++; if (lives_RGB !== exp_rgb) begin tests_failed++; $display("FAIL round_edge got %h exp %h", lives_RGB, exp_rgb); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_lose();
    test_gain();
    test_saturate();
    test_reset_mid();
    test_zero();
`ifdef LIVES_HUD_ROUND_ICON_EN
    test_round();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
